// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: register/dest-source
// widths, writeback source codes and the sequencer state type.
package hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned DEST_SRC_W = 2;

    localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU = 2'd0;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM = 2'd1;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_PC4 = 2'd2;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_CSR = 2'd3;

    localparam int unsigned HC_ST_W = 1;

    typedef enum logic [HC_ST_W-1:0] {
        HC_RST = 1'b0,
        HC_RUN = 1'b1
    } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: post-reset flush, memory-wait stalls, branch flushes
// and load-use bubbles for the fe/id/ex/me/wb chain, plus event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_WAIT     = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [REG_IDX_W-1:0]  i_id_rs1,
    input  logic [REG_IDX_W-1:0]  i_id_rs2,
    input  logic                  i_id_rs1_en,
    input  logic                  i_id_rs2_en,
    input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
    input  logic [DEST_SRC_W-1:0] i_ex_dest_src,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_me_busy,
    output logic                  o_fe_clr,
    output logic                  o_fe_stall,
    output logic                  o_id_clr,
    output logic                  o_id_stall,
    output logic                  o_ex_clr,
    output logic                  o_ex_stall,
    output logic                  o_me_clr,
    output logic                  o_me_stall,
    output logic                  o_wb_clr,
    output logic                  o_wb_stall,
    output logic                  o_rf_resetn,
    output logic                  o_redirect,
    output logic [CNT_W-1:0]      o_loaduse_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt,
    output logic [CNT_W-1:0]      o_mwait_cnt,
    output logic                  o_mem_timeout
);

    localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned WAIT_W    = $clog2(MAX_WAIT + 1);

    hc_state_e            state_q, state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 timeout_q, timeout_d;
    logic                 inc_loaduse, inc_flush, inc_mwait;
    logic                 loaduse_hit;

    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign loaduse_hit = (i_ex_dest_src == DEST_SRC_MEM) && (i_ex_dest_reg != '0) &&
                         ((i_id_rs1_en && (i_id_rs1 == i_ex_dest_reg)) ||
                          (i_id_rs2_en && (i_id_rs2 == i_ex_dest_reg)));

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wait_d      = '0;
        timeout_d   = timeout_q;
        inc_loaduse = 1'b0;
        inc_flush   = 1'b0;
        inc_mwait   = 1'b0;
        o_fe_clr    = 1'b0;
        o_fe_stall  = 1'b0;
        o_id_clr    = 1'b0;
        o_id_stall  = 1'b0;
        o_ex_clr    = 1'b0;
        o_ex_stall  = 1'b0;
        o_me_clr    = 1'b0;
        o_me_stall  = 1'b0;
        o_wb_clr    = 1'b0;
        o_wb_stall  = 1'b0;
        o_rf_resetn = 1'b1;
        o_redirect  = 1'b0;

        case (state_q)
            HC_RUN: begin
                if (i_me_busy) begin
                    o_fe_stall = 1'b1;
                    o_id_stall = 1'b1;
                    o_ex_stall = 1'b1;
                    o_me_stall = 1'b1;
                    o_wb_clr   = 1'b1;
                    inc_mwait  = 1'b1;
                    // Timeout latches on the edge that brings the count to MAX_WAIT.
                    if (wait_q >= WAIT_W'(MAX_WAIT - 1)) begin
                        wait_d    = WAIT_W'(MAX_WAIT);
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else if (i_ex_branch_taken) begin
                    o_id_clr   = 1'b1;
                    o_ex_clr   = 1'b1;
                    o_redirect = 1'b1;
                    inc_flush  = 1'b1;
                end else if (loaduse_hit) begin
                    o_fe_stall  = 1'b1;
                    o_id_stall  = 1'b1;
                    o_ex_clr    = 1'b1;
                    inc_loaduse = 1'b1;
                end
            end
            default: begin
                o_fe_clr    = 1'b1;
                o_id_clr    = 1'b1;
                o_ex_clr    = 1'b1;
                o_me_clr    = 1'b1;
                o_wb_clr    = 1'b1;
                o_rf_resetn = 1'b0;
                if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) begin
                    state_d   = HC_RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= HC_RST;
            rst_cnt_q <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_loaduse),
        .q      (o_loaduse_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_flush),
        .q      (o_flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mwait_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_mwait),
        .q      (o_mwait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with MAX_WAIT=4 and CNT_W=3.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CW = 3;

    // Stage control vector order: fe clr/stall, id, ex, me, wb.
    localparam logic [9:0] CTL_RST  = 10'b10_10_10_10_10;
    localparam logic [9:0] CTL_IDLE = 10'b00_00_00_00_00;
    localparam logic [9:0] CTL_MW   = 10'b01_01_01_01_10;
    localparam logic [9:0] CTL_BR   = 10'b00_10_10_00_00;
    localparam logic [9:0] CTL_LU   = 10'b01_01_10_00_00;

    logic                  clk;
    logic                  resetn;
    logic [REG_IDX_W-1:0]  i_id_rs1, i_id_rs2, i_ex_dest_reg;
    logic                  i_id_rs1_en, i_id_rs2_en;
    logic [DEST_SRC_W-1:0] i_ex_dest_src;
    logic                  i_ex_branch_taken, i_me_busy;
    logic o_fe_clr, o_fe_stall, o_id_clr, o_id_stall, o_ex_clr, o_ex_stall;
    logic o_me_clr, o_me_stall, o_wb_clr, o_wb_stall, o_rf_resetn, o_redirect;
    logic [CW-1:0]         o_loaduse_cnt, o_flush_cnt, o_mwait_cnt;
    logic                  o_mem_timeout;
    logic [9:0]            ctl;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.RESET_CYCLES(4), .MAX_WAIT(4), .CNT_W(CW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_id_rs1          (i_id_rs1),
        .i_id_rs2          (i_id_rs2),
        .i_id_rs1_en       (i_id_rs1_en),
        .i_id_rs2_en       (i_id_rs2_en),
        .i_ex_dest_reg     (i_ex_dest_reg),
        .i_ex_dest_src     (i_ex_dest_src),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_me_busy         (i_me_busy),
        .o_fe_clr          (o_fe_clr),
        .o_fe_stall        (o_fe_stall),
        .o_id_clr          (o_id_clr),
        .o_id_stall        (o_id_stall),
        .o_ex_clr          (o_ex_clr),
        .o_ex_stall        (o_ex_stall),
        .o_me_clr          (o_me_clr),
        .o_me_stall        (o_me_stall),
        .o_wb_clr          (o_wb_clr),
        .o_wb_stall        (o_wb_stall),
        .o_rf_resetn       (o_rf_resetn),
        .o_redirect        (o_redirect),
        .o_loaduse_cnt     (o_loaduse_cnt),
        .o_flush_cnt       (o_flush_cnt),
        .o_mwait_cnt       (o_mwait_cnt),
        .o_mem_timeout     (o_mem_timeout)
    );

    assign ctl = {o_fe_clr, o_fe_stall, o_id_clr, o_id_stall, o_ex_clr, o_ex_stall,
                  o_me_clr, o_me_stall, o_wb_clr, o_wb_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_id_rs1 = '0; i_id_rs2 = '0; i_id_rs1_en = 1'b0; i_id_rs2_en = 1'b0;
        i_ex_dest_reg = '0; i_ex_dest_src = DEST_SRC_ALU;
        i_ex_branch_taken = 1'b0; i_me_busy = 1'b0;
    endtask

    // Two reset edges, then four release edges so RUN is active on return.
    task automatic reset_pulse();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctl !== CTL_RST || o_rf_resetn !== 1'b0 || o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold ctl=%b rf=%b redir=%b expected ctl=%b rf=0 redir=0",
                     ctl, o_rf_resetn, o_redirect, CTL_RST);
        end
        checks++;
        if (o_loaduse_cnt !== '0 || o_flush_cnt !== '0 || o_mwait_cnt !== '0 || o_mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters lu=%0d fl=%0d mw=%0d to=%b expected 0 0 0 0",
                     o_loaduse_cnt, o_flush_cnt, o_mwait_cnt, o_mem_timeout);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_RST || o_rf_resetn !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_%0d ctl=%b rf=%b expected ctl=%b rf=0",
                         i, ctl, o_rf_resetn, CTL_RST);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (ctl !== CTL_IDLE || o_rf_resetn !== 1'b1 || o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_run ctl=%b rf=%b redir=%b expected ctl=%b rf=1 redir=0",
                     ctl, o_rf_resetn, o_redirect, CTL_IDLE);
        end
    endtask

    task automatic test_load_use();
        reset_pulse();
        i_ex_dest_src = DEST_SRC_MEM; i_ex_dest_reg = 5'd5;
        i_id_rs1 = 5'd5; i_id_rs1_en = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LU || o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_rs1 ctl=%b redir=%b expected ctl=%b redir=0", ctl, o_redirect, CTL_LU);
        end
        @(negedge clk);
        i_ex_dest_src = DEST_SRC_ALU; i_ex_dest_reg = 5'd9;
        #1;
        checks++;
        if (ctl !== CTL_IDLE || o_loaduse_cnt !== 3'd1) begin
            errors++;
            $display("FAIL loaduse_one_bubble ctl=%b cnt=%0d expected ctl=%b cnt=1", ctl, o_loaduse_cnt, CTL_IDLE);
        end
        @(negedge clk);
        i_ex_dest_src = DEST_SRC_MEM; i_ex_dest_reg = 5'd0; i_id_rs1 = 5'd0;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL loaduse_x0 ctl=%b expected %b", ctl, CTL_IDLE);
        end
        @(negedge clk);
        i_ex_dest_reg = 5'd7; i_id_rs1 = 5'd7; i_id_rs1_en = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL loaduse_rs1_disabled ctl=%b expected %b", ctl, CTL_IDLE);
        end
        @(negedge clk);
        i_id_rs1 = 5'd3; i_id_rs2 = 5'd7; i_id_rs2_en = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++;
            $display("FAIL loaduse_rs2 ctl=%b expected %b", ctl, CTL_LU);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (o_loaduse_cnt !== 3'd2 || o_flush_cnt !== 3'd0) begin
            errors++;
            $display("FAIL loaduse_count lu=%0d fl=%0d expected lu=2 fl=0", o_loaduse_cnt, o_flush_cnt);
        end
    endtask

    task automatic test_branch_loaduse();
        reset_pulse();
        i_ex_branch_taken = 1'b1;
        i_ex_dest_src = DEST_SRC_MEM; i_ex_dest_reg = 5'd5;
        i_id_rs1 = 5'd5; i_id_rs1_en = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_BR || o_redirect !== 1'b1) begin
            errors++;
            $display("FAIL branch_over_loaduse ctl=%b redir=%b expected ctl=%b redir=1", ctl, o_redirect, CTL_BR);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (o_flush_cnt !== 3'd1 || o_loaduse_cnt !== 3'd0) begin
            errors++;
            $display("FAIL branch_counts fl=%0d lu=%0d expected fl=1 lu=0", o_flush_cnt, o_loaduse_cnt);
        end
    endtask

    task automatic test_mem_wait();
        reset_pulse();
        i_me_busy = 1'b1; i_ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_MW || o_redirect !== 1'b0) begin
                errors++;
                $display("FAIL memwait_cycle_%0d ctl=%b redir=%b expected ctl=%b redir=0",
                         i, ctl, o_redirect, CTL_MW);
            end
            @(negedge clk);
        end
        i_me_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_BR || o_redirect !== 1'b1 || o_mwait_cnt !== 3'd3 || o_mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL memwait_deferred_branch ctl=%b redir=%b mw=%0d to=%b expected ctl=%b redir=1 mw=3 to=0",
                     ctl, o_redirect, o_mwait_cnt, o_mem_timeout, CTL_BR);
        end
        @(negedge clk);
        i_ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (o_flush_cnt !== 3'd1 || ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL memwait_flush_count fl=%0d ctl=%b expected fl=1 ctl=%b", o_flush_cnt, ctl, CTL_IDLE);
        end
    endtask

    task automatic test_timeout();
        reset_pulse();
        i_me_busy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            #1;
            checks++;
            if (o_mem_timeout !== (k >= 5)) begin
                errors++;
                $display("FAIL timeout_busy_cycle_%0d got=%b expected=%b", k, o_mem_timeout, (k >= 5));
            end
            @(negedge clk);
        end
        i_me_busy = 1'b0;
        #1;
        checks++;
        if (o_mem_timeout !== 1'b1 || o_mwait_cnt !== 3'd6 || ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL timeout_after_busy to=%b mw=%0d ctl=%b expected to=1 mw=6 ctl=%b",
                     o_mem_timeout, o_mwait_cnt, ctl, CTL_IDLE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_mem_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b expected=1", o_mem_timeout);
        end
        // Reset asserted mid-wait must win over the pending stall.
        i_me_busy = 1'b1; i_ex_branch_taken = 1'b1;
        resetn = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_MW) begin
            errors++;
            $display("FAIL midrun_reset_before_edge ctl=%b expected %b", ctl, CTL_MW);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== CTL_RST || o_rf_resetn !== 1'b0 || o_mem_timeout !== 1'b0 || o_mwait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL midrun_reset ctl=%b rf=%b to=%b mw=%0d expected ctl=%b rf=0 to=0 mw=0",
                     ctl, o_rf_resetn, o_mem_timeout, o_mwait_cnt, CTL_RST);
        end
        idle_inputs();
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturation();
        reset_pulse();
        i_ex_branch_taken = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_flush_cnt !== ((i > 7) ? 3'd7 : 3'(i))) begin
                errors++;
                $display("FAIL flush_sat_%0d got=%0d expected=%0d", i, o_flush_cnt, (i > 7) ? 7 : i);
            end
        end
        i_ex_branch_taken = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_loaduse();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline sequencer for the five-stage core (fe/id/ex/me/wb). Drives every stage's `clr`/`stall` pair and the register-file reset, sequences post-reset pipeline flushing, and resolves load-use hazards, taken-branch flushes and multi-cycle memory waits. Keeps saturating performance counters and a sticky memory-timeout flag. Sits beside the stage chain and replaces the per-stage clr/stall inputs that are currently driven by hand.

## Interface
- `RESET_CYCLES`, 4: cycles all stages are held cleared after `resetn` rises.
- `MAX_WAIT`, 255: consecutive `i_me_busy` cycles before `o_mem_timeout` sets.
- `CNT_W`, 32: performance counter width.
- `clk`  in  1  single clock, all state on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `i_id_rs1`, `i_id_rs2`  in  `REG_IDX_W`  sources of the instruction at the ID output.
- `i_id_rs1_en`, `i_id_rs2_en`  in  1  source actually read.
- `i_ex_dest_reg`  in  `REG_IDX_W`  destination of the instruction at the EX output.
- `i_ex_dest_src`  in  `DEST_SRC_W`  writeback source; `DEST_SRC_MEM` marks a load.
- `i_ex_branch_taken`  in  1  EX resolved a taken branch/jump.
- `i_me_busy`  in  1  ME cannot complete this cycle.
- `o_fe_clr`, `o_fe_stall`, `o_id_clr`, `o_id_stall`, `o_ex_clr`, `o_ex_stall`, `o_me_clr`, `o_me_stall`, `o_wb_clr`, `o_wb_stall`  out  1 each  per-stage controls.
- `o_rf_resetn`  out  1  register-file reset, low while in RST.
- `o_redirect`  out  1  fetch must load the branch target this edge.
- `o_loaduse_cnt`, `o_flush_cnt`, `o_mwait_cnt`  out  `CNT_W`  event counters.
- `o_mem_timeout`  out  1  sticky.

## Operation
- Stage semantics: `clr` loads a bubble at the next edge, `stall` holds the stage register; `clr` dominates `stall`.
- FSM states RST, RUN.
  - `resetn`=0 at an edge: state←RST, reset counter←0, all counters←0, `o_mem_timeout`←0, wait counter←0.
  - In RST: all `*_clr`=1, all `*_stall`=0, `o_rf_resetn`=0, `o_redirect`=0. Reset counter increments each cycle; on the cycle it reaches `RESET_CYCLES-1` the state moves to RUN.
- In RUN, `o_rf_resetn`=1. Conditions are evaluated in priority order, and only the first match applies.
  1. Memory wait, `i_me_busy`=1: stall fe, id, ex, me; clr wb; `o_redirect`=0. `o_mwait_cnt`++.
  2. Branch, `i_ex_branch_taken`=1: clr id and ex; `o_redirect`=1; fe loads the target. `o_flush_cnt`++. Load-use is ignored because the consumer is on the wrong path.
  3. Load-use: `i_ex_dest_src`==`DEST_SRC_MEM`, `i_ex_dest_reg`≠0, and an enabled `i_id_rsN` equals `i_ex_dest_reg`. Action: stall fe and id; clr ex. `o_loaduse_cnt`++.
  4. Otherwise all controls are 0.
- Register x0 never creates a hazard.
- A branch arriving during a memory wait is deferred. EX is stalled, so the branch is still asserted when the wait ends.
- Counters saturate at all-ones and never wrap.
- Wait counter: increments while `i_me_busy`=1 in RUN and clears when it is 0. When it reaches `MAX_WAIT`, `o_mem_timeout`←1 and stays set until reset. The pipeline stays stalled regardless.

## Timing
- Control outputs are combinational from state and the current inputs, with zero-cycle latency. Counters and the timeout flag update at the edge after the event.
- Reset values: state RST, all clr=1, stall=0, `o_rf_resetn`=0, `o_redirect`=0, counters 0, `o_mem_timeout`=0.
- Reset release: `resetn` high for `RESET_CYCLES` edges, then RUN is active in the following cycle.
- Reset asserted mid-run: the next edge enters RST regardless of pending hazards or waits.
- Load-use costs exactly one bubble. The next cycle the load sits at the ME output, and the hazard condition no longer matches.

## Structure
- Add to `config.vh`/`opcodes.vh`: the state encoding (`HC_ST_W`, `HC_RST`, `HC_RUN`). `DEST_SRC_MEM` and `REG_IDX_W` are already defined there.
- Single sub-module `sat_counter` (parameter `W`; ports `clk`, `resetn`, `inc`, `q`), instantiated three times.
- The hazard compare stays inline.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles, then release. Expect all clr=1 and `o_rf_resetn`=0 for exactly 4 edges after release, then all controls=0 and `o_rf_resetn`=1.
- Load-use: EX output is a load to x5 (`DEST_SRC_MEM`), ID reads rs1=x5. Expect `o_fe_stall`=`o_id_stall`=`o_ex_clr`=1 for one cycle and `o_loaduse_cnt`=1. Repeat with dest=x0: no stall.
- Branch plus load-use in the same cycle: expect `o_id_clr`=`o_ex_clr`=`o_redirect`=1, no stalls, `o_flush_cnt`=1, `o_loaduse_cnt`=0.
- Memory wait: `i_me_busy` high for 3 cycles with `i_ex_branch_taken`=1. Expect fe–me stalled and wb cleared for 3 cycles, `o_mwait_cnt`=3, then `o_redirect`=1 on cycle 4.
- Timeout with `MAX_WAIT`=4: hold `i_me_busy` for 6 cycles. Expect `o_mem_timeout`=1 from the edge after the 4th busy cycle, still 1 after busy drops, and cleared only by `resetn`.
- Saturation with `CNT_W`=3: 9 branch flushes give `o_flush_cnt`=7.
